// File: rtl/ksa_param.sv
// ksa_param: ARC4 key-scheduling engine driving a single-port S-box memory.
// Optionally fills S[i]=i, then runs the 256-step KSA swap loop using a key
// of KEY_BYTES bytes (byte 0 in the MSBs of key).
//
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   en / rdy    : start request / idle indication (accepted when both high)
//   key         : KEY_BYTES*8-bit key, latched on acceptance
//   addr        : S memory address
//   rddata      : S memory read data, valid READ_LAT cycles after addr
//   wrdata/wren : S memory write data / write enable
//   done        : one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for en
// INIT  | writing S[i]=i, one entry per cycle
// RD_I  | presenting addr=i for read
// WT_I  | waiting for S[i], captured into si at the last wait cycle
// RD_J  | registering j_new and presenting it as read address
// WT_J  | waiting for S[j], captured into sj at the last wait cycle
// WR_I  | writing S[i]=sj
// WR_J  | writing S[j]=si, advancing i and kidx
// FIN   | done pulse, ready for a back-to-back start
module ksa_param #(
   parameter int KEY_BYTES = 3,
   parameter int READ_LAT  = 1,
   parameter int INIT_EN   = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   output logic                   rdy,
   input  logic [KEY_BYTES*8-1:0] key,
   output logic [7:0]             addr,
   input  logic [7:0]             rddata,
   output logic [7:0]             wrdata,
   output logic                   wren,
   output logic                   done
);

   localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

   typedef enum logic [3:0] {
      IDLE, INIT, RD_I, WT_I, RD_J, WT_J, WR_I, WR_J, FIN
   } state_t;

   state_t                 state, state_nxt;
   logic [7:0]             i_q, j_q, si_q, sj_q;
   logic [KW-1:0]          kidx_q;
   logic [KEY_BYTES*8-1:0] key_q;
   logic [1:0]             wait_q;
   logic                   start;
   logic                   wait_tc;
   logic [7:0]             key_byte;
   logic [7:0]             j_new;

   assign start   = en && rdy;
   assign wait_tc = (wait_q == 2'd0);

   // Byte select by comparison mux so no variable-width shift or divide is built.
   always_comb begin
      key_byte = 8'd0;
      for (int k = 0; k < KEY_BYTES; k++) begin
         if (kidx_q == KW'(k)) key_byte = key_q[(KEY_BYTES-1-k)*8 +: 8];
      end
   end

   assign j_new = j_q + si_q + key_byte;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, FIN: begin
            if (start) state_nxt = (INIT_EN != 0) ? INIT : RD_I;
            else       state_nxt = IDLE;
         end
         INIT:    if (i_q == 8'hFF) state_nxt = RD_I;
         RD_I:    state_nxt = WT_I;
         WT_I:    if (wait_tc) state_nxt = RD_J;
         RD_J:    state_nxt = WT_J;
         WT_J:    if (wait_tc) state_nxt = WR_I;
         WR_I:    state_nxt = WR_J;
         WR_J:    state_nxt = (i_q == 8'hFF) ? FIN : RD_I;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_q    <= 8'd0;
         j_q    <= 8'd0;
         si_q   <= 8'd0;
         sj_q   <= 8'd0;
         kidx_q <= '0;
         key_q  <= '0;
         wait_q <= 2'd0;
      end else begin
         case (state)
            IDLE, FIN: begin
               if (start) begin
                  key_q  <= key;
                  i_q    <= 8'd0;
                  j_q    <= 8'd0;
                  kidx_q <= '0;
               end
            end
            INIT: i_q <= i_q + 8'd1;
            RD_I: wait_q <= 2'(READ_LAT - 1);
            WT_I: begin
               if (wait_tc) si_q   <= rddata;
               else         wait_q <= wait_q - 2'd1;
            end
            RD_J: begin
               j_q    <= j_new;
               wait_q <= 2'(READ_LAT - 1);
            end
            WT_J: begin
               if (wait_tc) sj_q   <= rddata;
               else         wait_q <= wait_q - 2'd1;
            end
            WR_J: begin
               kidx_q <= (kidx_q == KW'(KEY_BYTES - 1)) ? '0 : kidx_q + KW'(1);
               i_q    <= i_q + 8'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      rdy    = 1'b0;
      done   = 1'b0;
      wren   = 1'b0;
      addr   = 8'd0;
      wrdata = 8'd0;
      case (state)
         IDLE: rdy = 1'b1;
         INIT: begin
            addr   = i_q;
            wrdata = i_q;
            wren   = 1'b1;
         end
         RD_I: addr = i_q;
         RD_J: addr = j_new;
         WR_I: begin
            addr   = i_q;
            wrdata = sj_q;
            wren   = 1'b1;
         end
         WR_J: begin
            addr   = j_q;
            wrdata = si_q;
            wren   = 1'b1;
         end
         FIN: begin
            done = 1'b1;
            rdy  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ksa_param.sv
// Testbench for ksa_param: three instances (3-byte key / READ_LAT 1 / fill,
// 1-byte key / READ_LAT 2 / no fill, 5-byte key / READ_LAT 1 / fill), each
// with its own behavioural 256x8 memory. Expected results are queued at
// stimulus time and checked by a monitor whenever an instance pulses done.
module tb_ksa_param;

   typedef struct packed {
      logic [31:0]   cyc;
      logic [31:0]   wr;
      logic [2047:0] s;
   } exp_t;

   logic              clk;
   logic              rst_n;
   logic [2:0]        en, rdy, done, wren;
   logic [2:0][7:0]   addr, wrdata;
   logic [7:0]        rd_pipe [3][2];
   logic [7:0]        mem [3][256];
   logic [23:0]       key_a;
   logic [7:0]        key_b;
   logic [39:0]       key_c;
   logic              pre_b, rst_chk, fin_req, fin_done;

   exp_t q0[$], q1[$], q2[$];

   int nvec = 0;
   int nerr = 0;
   logic [2:0] busy;
   int cnt [3];
   int wcnt [3];
   int rbad [3];

   ksa_param #(.KEY_BYTES(3), .READ_LAT(1), .INIT_EN(1)) u_a (
      .clk(clk), .rst_n(rst_n), .en(en[0]), .rdy(rdy[0]), .key(key_a),
      .addr(addr[0]), .rddata(rd_pipe[0][0]), .wrdata(wrdata[0]),
      .wren(wren[0]), .done(done[0]));

   ksa_param #(.KEY_BYTES(1), .READ_LAT(2), .INIT_EN(0)) u_b (
      .clk(clk), .rst_n(rst_n), .en(en[1]), .rdy(rdy[1]), .key(key_b),
      .addr(addr[1]), .rddata(rd_pipe[1][1]), .wrdata(wrdata[1]),
      .wren(wren[1]), .done(done[1]));

   ksa_param #(.KEY_BYTES(5), .READ_LAT(1), .INIT_EN(1)) u_c (
      .clk(clk), .rst_n(rst_n), .en(en[2]), .rdy(rdy[2]), .key(key_c),
      .addr(addr[2]), .rddata(rd_pipe[2][0]), .wrdata(wrdata[2]),
      .wren(wren[2]), .done(done[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous memories: read data appears one (or two) cycles after addr.
   always @(posedge clk) begin
      if (pre_b) begin
         for (int x = 0; x < 256; x++) mem[1][x] <= 8'(x);
      end
      for (int g = 0; g < 3; g++) begin
         if (wren[g]) mem[g][addr[g]] <= wrdata[g];
         rd_pipe[g][0] <= mem[g][addr[g]];
         rd_pipe[g][1] <= rd_pipe[g][0];
      end
   end

   function automatic logic [2047:0] ksa_model(input logic [39:0] k, input int n);
      logic [7:0]    s [256];
      logic [7:0]    j, t, kb;
      logic [2047:0] r;
      for (int x = 0; x < 256; x++) s[x] = 8'(x);
      j = 8'd0;
      for (int x = 0; x < 256; x++) begin
         kb   = k[(n - 1 - (x % n)) * 8 +: 8];
         j    = j + s[x] + kb;
         t    = s[x];
         s[x] = s[j];
         s[j] = t;
      end
      for (int x = 0; x < 256; x++) r[x*8 +: 8] = s[x];
      return r;
   endfunction

   function automatic int qsize(input int g);
      case (g)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] want);
      nvec++;
      if (act !== want) begin
         nerr++;
         $display("FAIL %s inst%0d: got %0d expected %0d", name, g, act, want);
      end
   endtask

   task automatic chk_s(input int g, input logic [2047:0] want);
      int bad   = 0;
      int first = -1;
      nvec++;
      for (int x = 0; x < 256; x++) begin
         if (mem[g][x] !== want[x*8 +: 8]) begin
            bad++;
            if (first < 0) first = x;
         end
      end
      if (bad != 0) begin
         nerr++;
         $display("FAIL sbox inst%0d: %0d bad entries, first S[%0d] got %h expected %h",
                  g, bad, first, mem[g][first], want[first*8 +: 8]);
      end
   endtask

   // Monitor / scoreboard: sole owner of the comparison counters.
   always @(negedge clk) begin
      exp_t e;
      if (rst_chk) begin
         chk("rst_rdy",  0, 32'(rdy[0]),  32'd1);
         chk("rst_wren", 0, 32'(wren[0]), 32'd0);
         chk("rst_addr", 0, 32'(addr[0]), 32'd0);
         chk("rst_done", 0, 32'(done[0]), 32'd0);
      end
      if (!rst_n) begin
         busy = 3'b000;
      end else begin
         for (int g = 0; g < 3; g++) begin
            if (busy[g]) begin
               cnt[g]++;
               if (wren[g]) wcnt[g]++;
               if (rdy[g] && !done[g]) rbad[g]++;
               if (cnt[g] > 5000) begin
                  nvec++;
                  nerr++;
                  $display("FAIL timeout inst%0d: no done after %0d cycles", g, cnt[g]);
                  busy[g] = 1'b0;
               end
            end
            if (done[g]) begin
               if (!busy[g] || qsize(g) == 0) begin
                  nvec++;
                  nerr++;
                  $display("FAIL unexpected_done inst%0d: got done=1 expected none", g);
               end else begin
                  case (g)
                     0:       e = q0.pop_front();
                     1:       e = q1.pop_front();
                     default: e = q2.pop_front();
                  endcase
                  chk("cycles",       g, 32'(cnt[g]),  e.cyc);
                  chk("write_count",  g, 32'(wcnt[g]), e.wr);
                  chk("rdy_in_run",   g, 32'(rbad[g]), 32'd0);
                  chk("rdy_at_done",  g, 32'(rdy[g]),  32'd1);
                  chk("wren_at_done", g, 32'(wren[g]), 32'd0);
                  chk_s(g, e.s);
               end
               busy[g] = 1'b0;
            end
            if (en[g] && rdy[g]) begin
               busy[g] = 1'b1;
               cnt[g]  = 0;
               wcnt[g] = 0;
               rbad[g] = 0;
            end
         end
      end
      if (fin_req && !fin_done) begin
         for (int g = 0; g < 3; g++) chk("pending_runs", g, 32'(qsize(g)), 32'd0);
         fin_done = 1'b1;
      end
   end

   task automatic push(input int g, input int cyc, input int wr, input logic [2047:0] s);
      exp_t e;
      e.cyc = 32'(cyc);
      e.wr  = 32'(wr);
      e.s   = s;
      case (g)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic pulse(input int g);
      en[g] = 1'b1;
      @(posedge clk);
      #1 en[g] = 1'b0;
   endtask

   task automatic drain(input int g);
      for (int c = 0; c < 6000; c++) begin
         if (qsize(g) == 0) break;
         @(posedge clk);
      end
      #1;
   endtask

   initial begin
      rst_n = 1'b0; en = 3'b000; key_a = '0; key_b = '0; key_c = '0;
      pre_b = 1'b0; rst_chk = 1'b0; fin_req = 1'b0; fin_done = 1'b0;
      busy = 3'b000;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic run, 3-byte key, fill + KSA: 256 + 256*6 + 1 cycles.
      key_a = 24'h00033C;
      push(0, 1793, 768, ksa_model(40'h00033C, 3));
      pulse(0);
      drain(0);

      // All-zero key.
      key_a = 24'h000000;
      push(0, 1793, 768, ksa_model(40'h000000, 3));
      pulse(0);
      drain(0);

      // en held high, key changed mid-run; second run starts at the FIN edge
      // and latches the key present at that edge.
      key_a = 24'h00033C;
      push(0, 1793, 768, ksa_model(40'h00033C, 3));
      push(0, 1793, 768, ksa_model(40'hFFFFFF, 3));
      en[0] = 1'b1;
      repeat (100) @(posedge clk);
      #1 key_a = 24'hFFFFFF;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         if (q0.size() <= 1) break;
      end
      #1 en[0] = 1'b0;
      drain(0);

      // Reset at cycle 700 of a run, then a full fresh run.
      key_a = 24'h00033C;
      pulse(0);
      repeat (699) @(posedge clk);
      #1 rst_n = 1'b0;
      rst_chk = 1'b1;
      @(negedge clk);
      #1 rst_chk = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      push(0, 1793, 768, ksa_model(40'h00033C, 3));
      pulse(0);
      drain(0);

      // Single-byte key, READ_LAT 2, no fill: memory preloaded S[i]=i.
      pre_b = 1'b1;
      @(posedge clk);
      #1 pre_b = 1'b0;
      key_b = 8'hA5;
      push(1, 2049, 512, ksa_model(40'h00000000A5, 1));
      pulse(1);
      drain(1);

      // Five-byte key: byte order and key index wrap at 4.
      key_c = 40'h0102030405;
      push(2, 1793, 768, ksa_model(40'h0102030405, 5));
      pulse(2);
      drain(2);

      fin_req = 1'b1;
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
